// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset PC, next-PC source and branch-condition encodings,
// plus the delay-slot state type used by pc_ctrl when PC_DELAY_SLOT_EN is defined.
package cpu_pkg;

   localparam logic [31:0] RESET_PC   = 32'h0000_3000;

   localparam logic [1:0]  NPC_SEQ    = 2'd0;
   localparam logic [1:0]  NPC_BRANCH = 2'd1;
   localparam logic [1:0]  NPC_JUMP   = 2'd2;
   localparam logic [1:0]  NPC_JR     = 2'd3;

   localparam logic [1:0]  BR_EQ      = 2'd0;
   localparam logic [1:0]  BR_NE      = 2'd1;
   localparam logic [1:0]  BR_LT      = 2'd2;
   localparam logic [1:0]  BR_GE      = 2'd3;

   typedef enum logic {
      DS_IDLE = 1'b0,
      DS_SLOT = 1'b1
   } ds_state_t;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC target selection: branch/jump/jr target, redirect request
// and jr misalignment flag, all derived from the current PC and decoded fields.
module npc_calc
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [1:0]        npc_sel,
   input  logic [1:0]        br_cond,
   input  logic              zero,
   input  logic              less,
   input  logic [15:0]       imm16,
   input  logic [25:0]       instr_index,
   input  logic [ADDR_W-1:0] rs_val,
   output logic [ADDR_W-1:0] target,
   output logic              taken,
   output logic              misalign
);

   logic [ADDR_W-1:0] p4;
   logic              cond_ok;

   assign p4 = pc + ADDR_W'(4);

   always_comb begin
      cond_ok = 1'b0;
      case (br_cond)
         BR_EQ:   cond_ok = zero;
         BR_NE:   cond_ok = ~zero;
         BR_LT:   cond_ok = less;
         default: cond_ok = ~less;
      endcase
   end

   always_comb begin
      target   = p4;
      taken    = 1'b0;
      misalign = 1'b0;
      case (npc_sel)
         NPC_BRANCH: begin
            // Offset is a signed word count; the add wraps modulo 2^32.
            target = p4 + {{14{imm16[15]}}, imm16, 2'b00};
            taken  = cond_ok;
         end
         NPC_JUMP: begin
            target = {p4[ADDR_W-1:ADDR_W-4], instr_index, 2'b00};
            taken  = 1'b1;
         end
         NPC_JR: begin
            // Low bits are dropped; the fault is only reported, never blocks the jump.
            target   = {rs_val[ADDR_W-1:2], 2'b00};
            taken    = 1'b1;
            misalign = (rs_val[1:0] != 2'b00);
         end
         default: begin
            target = p4;
            taken  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter register with next-PC selection. Define PC_DELAY_SLOT_EN to get
// MIPS branch-delay-slot behaviour (redirect applied one instruction late).
module pc_ctrl #(
   parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
   parameter int          ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic [1:0]        npc_sel,
   input  logic [1:0]        br_cond,
   input  logic              zero,
   input  logic              less,
   input  logic [15:0]       imm16,
   input  logic [25:0]       instr_index,
   input  logic [ADDR_W-1:0] rs_val,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] link_addr,
   output logic              taken,
   output logic              misalign
);

   import cpu_pkg::*;

   logic [ADDR_W-1:0] pc_reg;
   logic [ADDR_W-1:0] pc_next;
   logic [ADDR_W-1:0] p4;
   logic [ADDR_W-1:0] target;

   assign pc = pc_reg;
   assign p4 = pc_reg + ADDR_W'(4);

   npc_calc #(
      .ADDR_W      (ADDR_W)
   ) u_npc_calc (
      .pc          (pc_reg),
      .npc_sel     (npc_sel),
      .br_cond     (br_cond),
      .zero        (zero),
      .less        (less),
      .imm16       (imm16),
      .instr_index (instr_index),
      .rs_val      (rs_val),
      .target      (target),
      .taken       (taken),
      .misalign    (misalign)
   );

`ifdef PC_DELAY_SLOT_EN
   ds_state_t         state_reg;
   ds_state_t         state_next;
   logic [ADDR_W-1:0] pend_tgt_reg;
   logic [ADDR_W-1:0] pend_tgt_next;

   // jal links past the delay-slot instruction.
   assign link_addr = pc_reg + ADDR_W'(8);

   always_comb begin
      state_next    = state_reg;
      pend_tgt_next = pend_tgt_reg;
      pc_next       = p4;
      case (state_reg)
         DS_IDLE: begin
            if (taken) begin
               pend_tgt_next = target;
               state_next    = DS_SLOT;
            end
         end
         default: begin
            // Redirects requested from inside a delay slot are ignored.
            pc_next    = pend_tgt_reg;
            state_next = DS_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_reg       <= RESET_PC[ADDR_W-1:0];
         state_reg    <= DS_IDLE;
         pend_tgt_reg <= '0;
      end else if (!stall) begin
         pc_reg       <= pc_next;
         state_reg    <= state_next;
         pend_tgt_reg <= pend_tgt_next;
      end
   end
`else
   assign link_addr = p4;

   always_comb begin
      pc_next = taken ? target : p4;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_reg <= RESET_PC[ADDR_W-1:0];
      end else if (!stall) begin
         pc_reg <= pc_next;
      end
   end
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: stimulus pushes hand-computed per-cycle expectations,
// a negedge monitor pops and compares. Honours PC_DELAY_SLOT_EN if defined.
module tb_pc_ctrl;

   localparam logic [1:0] SEQ = 2'd0, BR = 2'd1, JMP = 2'd2, JR = 2'd3;
   localparam logic [1:0] EQ = 2'd0, NE = 2'd1, LT = 2'd2, GE = 2'd3;
`ifdef PC_DELAY_SLOT_EN
   localparam logic [31:0] LINK_OFF = 32'd8;
`else
   localparam logic [31:0] LINK_OFF = 32'd4;
`endif

   typedef struct {
      string       nm;
      logic [31:0] pc;
      logic [31:0] link;
      logic        tk;
      logic        mis;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic [1:0]  npc_sel;
   logic [1:0]  br_cond;
   logic        zero;
   logic        less;
   logic [15:0] imm16;
   logic [25:0] instr_index;
   logic [31:0] rs_val;
   logic [31:0] pc;
   logic [31:0] link_addr;
   logic        taken;
   logic        misalign;

   exp_t        sb[$];
   logic [31:0] ep;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   pc_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .npc_sel     (npc_sel),
      .br_cond     (br_cond),
      .zero        (zero),
      .less        (less),
      .imm16       (imm16),
      .instr_index (instr_index),
      .rs_val      (rs_val),
      .pc          (pc),
      .link_addr   (link_addr),
      .taken       (taken),
      .misalign    (misalign)
   );

   task automatic cmp(input string nm, input string fld, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s.%s got=%h want=%h", nm, fld, got, want);
      end
   endtask

   // Monitor: one transaction per cycle, compared away from the rising edge.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         cmp(e.nm, "pc", pc, e.pc);
         cmp(e.nm, "link", link_addr, e.link);
         cmp(e.nm, "taken", {31'd0, taken}, {31'd0, e.tk});
         cmp(e.nm, "misalign", {31'd0, misalign}, {31'd0, e.mis});
         $display("txn %-12s pc=%h link=%h taken=%b misalign=%b", e.nm, pc, link_addr, taken, misalign);
      end
   end

   // Called just after a rising edge: drive one cycle, queue its expectation.
   task automatic cyc(input string nm, input logic st, input logic [1:0] sel, input logic [1:0] cond,
                      input logic z, input logic l, input logic [15:0] imm, input logic [25:0] idx,
                      input logic [31:0] rs, input logic etk, input logic emis, input logic [31:0] nxt);
      exp_t e;
      stall = st; npc_sel = sel; br_cond = cond; zero = z; less = l;
      imm16 = imm; instr_index = idx; rs_val = rs;
      e.nm = nm; e.pc = ep; e.link = ep + LINK_OFF; e.tk = etk; e.mis = emis;
      sb.push_back(e);
      @(posedge clk); #1;
      ep = nxt;
   endtask

   task automatic seq_n(input int n, input string nm);
      for (int i = 0; i < n; i++) cyc(nm, 1'b0, SEQ, EQ, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, ep + 32'd4);
   endtask

   // Taken redirect to tgt; with delay slots the slot instruction at P+4 runs first.
   task automatic redirect(input string nm, input logic [1:0] sel, input logic [1:0] cond, input logic z,
                           input logic l, input logic [15:0] imm, input logic [25:0] idx,
                           input logic [31:0] rs, input logic emis, input logic [31:0] tgt);
`ifdef PC_DELAY_SLOT_EN
      cyc(nm, 1'b0, sel, cond, z, l, imm, idx, rs, 1'b1, emis, ep + 32'd4);
      cyc({nm, "_slot"}, 1'b0, SEQ, EQ, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, tgt);
`else
      cyc(nm, 1'b0, sel, cond, z, l, imm, idx, rs, 1'b1, emis, tgt);
`endif
   endtask

   // Reset raised mid-cycle; pc must show RESET_PC before the next edge.
   task automatic do_reset(input string nm);
      exp_t e;
      stall = 1'b0; npc_sel = SEQ; br_cond = EQ; zero = 1'b0; less = 1'b0;
      imm16 = 16'h0; instr_index = 26'h0; rs_val = 32'h0;
      #2 reset = 1'b1;
      #1;
      e.nm = nm; e.pc = 32'h0000_3000; e.link = 32'h0000_3000 + LINK_OFF; e.tk = 1'b0; e.mis = 1'b0;
      sb.push_back(e);
      @(posedge clk); #1;
      reset = 1'b0;
      ep = 32'h0000_3000;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; npc_sel = SEQ; br_cond = EQ; zero = 1'b0; less = 1'b0;
      imm16 = 16'h0; instr_index = 26'h0; rs_val = 32'h0; ep = 32'h0000_3000;
      @(posedge clk); #1;
      do_reset("rst0");
      seq_n(3, "seq");
      do_reset("rst_mid");

      seq_n(4, "to3010");
      redirect("beq_t", BR, EQ, 1'b1, 1'b0, 16'hFFFC, 26'h0, 32'h0, 1'b0, 32'h0000_3004);
      seq_n(1, "at3004");

      do_reset("rst");
      seq_n(4, "to3010");
      cyc("beq_nt", 1'b0, BR, EQ, 1'b0, 1'b0, 16'hFFFC, 26'h0, 32'h0, 1'b0, 1'b0, 32'h0000_3014);
      seq_n(1, "at3014");

      do_reset("rst");
      redirect("blt", BR, LT, 1'b0, 1'b1, 16'h0003, 26'h0, 32'h0, 1'b0, 32'h0000_3010);
      seq_n(1, "at3010");
      do_reset("rst");
      cyc("bge_nt", 1'b0, BR, GE, 1'b0, 1'b1, 16'h0003, 26'h0, 32'h0, 1'b0, 1'b0, 32'h0000_3004);
      seq_n(1, "at3004");

      do_reset("rst");
      seq_n(8, "to3020");
      redirect("jal", JMP, EQ, 1'b0, 1'b0, 16'h0, 26'h0000C10, 32'h0, 1'b0, 32'h0000_3040);
      seq_n(1, "at3040");

      do_reset("rst");
      seq_n(8, "to3020");
      redirect("jr_mis", JR, EQ, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0000_3101, 1'b1, 32'h0000_3100);
      seq_n(1, "at3100");

      do_reset("rst");
      redirect("jr_top", JR, EQ, 1'b0, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC);
      seq_n(1, "wrap");
      seq_n(1, "at0");

      do_reset("rst");
      cyc("bne_stall1", 1'b1, BR, NE, 1'b0, 1'b0, 16'h0010, 26'h0, 32'h0, 1'b1, 1'b0, 32'h0000_3000);
      cyc("bne_stall2", 1'b1, BR, NE, 1'b0, 1'b0, 16'h0010, 26'h0, 32'h0, 1'b1, 1'b0, 32'h0000_3000);
      redirect("bne_go", BR, NE, 1'b0, 1'b0, 16'h0010, 26'h0, 32'h0, 1'b0, 32'h0000_3044);
      seq_n(1, "at3044");

`ifdef PC_DELAY_SLOT_EN
      do_reset("rst");
      cyc("ds_beq", 1'b0, BR, EQ, 1'b1, 1'b0, 16'h003F, 26'h0, 32'h0, 1'b1, 1'b0, 32'h0000_3004);
      cyc("ds_ignored", 1'b0, BR, EQ, 1'b1, 1'b0, 16'h0010, 26'h0, 32'h0, 1'b1, 1'b0, 32'h0000_3100);
      cyc("ds_beq2", 1'b0, BR, EQ, 1'b1, 1'b0, 16'h003F, 26'h0, 32'h0, 1'b1, 1'b0, 32'h0000_3104);
      do_reset("ds_rst_slot");
      seq_n(2, "ds_after");
`endif

      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_drain got=%0d want=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Program-counter register and next-PC selection for the MIPS-subset CPU; sits directly downstream of the ALU.
- Consumes the ALU's zero/less compare flags, together with decoded control and instruction fields.
- Produces the fetch address (pc) for instruction memory and the link address for jal.
- The PC updates on every rising clock edge unless stalled.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- ADDR_W, 32, PC/address width (fixed 32 in this CPU; the parameter exists for lint only).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  1 = hold pc and all internal state this cycle.
- npc_sel  in  2  next-PC source: 0 SEQ, 1 BRANCH, 2 JUMP (j/jal), 3 JR.
- br_cond  in  2  branch condition, valid when npc_sel=BRANCH: 0 EQ, 1 NE, 2 LT, 3 GE.
- zero  in  1  ALU flag, A==B.
- less  in  1  ALU flag, signed A<B.
- imm16  in  16  branch offset field.
- instr_index  in  26  jump target field.
- rs_val  in  32  jr target register value.
- pc  out  32  current fetch address.
- link_addr  out  32  value written to $ra by jal.
- taken  out  1  combinational; 1 when this cycle requests a redirect.
- misalign  out  1  combinational; 1 when npc_sel=JR and rs_val[1:0]!=0.

Behaviour:
- Reset (async, any time, including mid-delay-slot): pc=RESET_PC, pending cleared. Combinational outputs follow from pc and inputs.
- Let P=pc and P4=P+4 (mod 2^32, wraps silently).
- Branch target: P4 + (sign_extend(imm16)<<2), computed as 32-bit with wrap.
- Jump target: {P4[31:28], instr_index, 2'b00}.
- JR target: {rs_val[31:2], 2'b00}. The low bits are cleared; misalign flags the fault but does not block the jump.
- cond_ok values: EQ=zero, NE=!zero, LT=less, GE=!less.
- taken = (npc_sel==BRANCH & cond_ok) | npc_sel==JUMP | npc_sel==JR.
- An untaken branch behaves as SEQ.
- Default (no macro), each clock edge with stall=0: pc <= taken ? target : P4. link_addr=P4.
- stall=1: pc holds. A stall has priority over everything except reset.
- Latency: a redirect decided in cycle n appears on pc in cycle n+1.
- npc_sel values are all defined; there is no illegal encoding.

Optional Feature:
- Macro: PC_DELAY_SLOT_EN.
- With the macro: MIPS branch-delay-slot semantics. Two states:
  - IDLE: on taken, latch target into pend_tgt and go to SLOT; pc <= P4.
  - SLOT: pc <= pend_tgt and return to IDLE. Redirect requests raised while in SLOT are ignored (a branch inside a delay slot is undefined in ISA terms and is defined here as ignored).
  - link_addr = P+8.
  - taken is still asserted combinationally in the request cycle.
  - stall freezes both the state and pend_tgt.
- Without the macro: no pending state; link_addr = P+4; behaviour exactly as in Behaviour.

Decomposition:
- Shared package cpu_pkg holds:
  - RESET_PC;
  - npc_sel encodings NPC_SEQ/NPC_BRANCH/NPC_JUMP/NPC_JR;
  - br_cond encodings BR_EQ/BR_NE/BR_LT/BR_GE.
- One combinational sub-module, npc_calc: takes P, npc_sel, br_cond, flags and fields; produces target, taken and misalign.
- pc_ctrl itself holds only the PC register and the optional delay-slot state.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> pc=0x0000_3000 immediately; after release with SEQ for 3 cycles -> 0x3004, 0x3008, 0x300C.
- BEQ taken/untaken at P=0x3010, imm16=0xFFFC:
  - zero=1 -> taken=1, next pc=0x3004;
  - zero=0 -> next pc=0x3014.
- LT/GE with less=1, imm16=0x0003, P=0x3000:
  - LT -> pc=0x3010;
  - GE -> pc=0x3004.
- J/JAL/JR at P=0x3020:
  - instr_index=0x0000C10 -> pc=0x0000_3040, link_addr=0x3024 (0x3028 with macro);
  - JR rs_val=0x0000_3101 -> misalign=1, next pc=0x0000_3100.
- Stall: stall=1 for 2 cycles during a taken BNE -> pc unchanged both cycles; redirect applied on the first cycle with stall=0.
- PC_DELAY_SLOT_EN: taken BEQ at 0x3000 to 0x3100 -> pc sequence 0x3004, 0x3100. A second taken branch issued at 0x3004 is ignored. Reset asserted while in SLOT -> pc=0x3000 and the pending target is discarded.
